// File: rtl/ospi_pkg.sv
// Shared opcodes, request encodings and FSM states for the OSPI host controller.
package ospi_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_ERASE = 8'h20;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_ERASE = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_IDLE     = 4'd1,
    ST_ERR      = 4'd2,
    ST_CS_SETUP = 4'd3,
    ST_CMD      = 4'd4,
    ST_ADDR     = 4'd5,
    ST_DUMMY    = 4'd6,
    ST_DATA     = 4'd7,
    ST_CS_HOLD  = 4'd8,
    ST_GAP      = 4'd9
  } state_e;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] opcode_of(cmd_op_e op);
    case (op)
      CMD_READ:  return OP_READ;
      CMD_WRITE: return OP_WRITE;
      CMD_ERASE: return OP_ERASE;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ospi_clk_gen.sv
// OSPI_CLK divider: toggles every CLK_DIV clk while enabled and flags the clk
// cycle in which the next rising/falling edge will be registered.
module ospi_clk_gen import ospi_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hold,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CW = cnt_w(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_evt = tick && !sclk;
  assign fall_evt = tick && sclk;

  // hold keeps the clock parked low while half-period ticks keep coming, so the
  // FSM can time CS hold and gap in half-periods without any clock edges.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= hold ? 1'b0 : ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ospi_host_ctrl.sv
// Host-side OSPI initiator: one READ/WRITE/ERASE request per handshake, sent as
// SDR octal frames (WREN frame first for WRITE/ERASE), one-cycle response strobe.
module ospi_host_ctrl import ospi_pkg::*; #(
  parameter int CLK_DIV     = 2,
  parameter int ADDR_W      = 8,
  parameter int DUMMY_CYC   = 4,
  parameter int CS_HIGH_MIN = 2,
  parameter int RST_CYC     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_cs,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              OSPI_CLK,
  output logic              OSPI_CS0_b,
  output logic              OSPI_CS1_b,
  output logic              OSPI_RST_b,
  output logic [7:0]        OSPI_IO_o,
  output logic              OSPI_IO_oe,
  input  logic [7:0]        OSPI_IO_i
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int BW = cnt_w(ADDR_BYTES);
  localparam int DW = cnt_w(DUMMY_CYC);
  localparam int GW = cnt_w(2 * CS_HIGH_MIN);
  localparam int RW = cnt_w(RST_CYC);

  state_e            state;
  cmd_op_e           op_q, req_op;
  logic              cs_q, wren_pend, clk_en, hold;
  logic [ADDR_W-1:0] addr_sh;
  logic [7:0]        wdata_q, rdata_q;
  logic [BW-1:0]     bcnt;
  logic [DW-1:0]     dcnt;
  logic [GW-1:0]     gcnt;
  logic [RW-1:0]     rcnt;
  logic              rise_evt, fall_evt;

  assign req_op = cmd_op_e'(cmd_op);
  assign hold   = (state == ST_CS_HOLD) || (state == ST_GAP);

  ospi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .hold     (hold),
    .sclk     (OSPI_CLK),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RST;
      cmd_ready  <= 1'b0;
      busy       <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= 1'b0;
      OSPI_CS0_b <= 1'b1;
      OSPI_CS1_b <= 1'b1;
      OSPI_RST_b <= 1'b0;
      OSPI_IO_o  <= 8'h00;
      OSPI_IO_oe <= 1'b0;
      clk_en     <= 1'b0;
      op_q       <= CMD_READ;
      cs_q       <= 1'b0;
      wren_pend  <= 1'b0;
      addr_sh    <= '0;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      bcnt       <= '0;
      dcnt       <= '0;
      gcnt       <= '0;
      rcnt       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
      case (state)
        ST_RST: begin
          if (rcnt == RW'(RST_CYC - 1)) begin
            rcnt       <= '0;
            OSPI_RST_b <= 1'b1;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= req_op;
            cs_q      <= cmd_cs;
            addr_sh   <= cmd_addr;
            wdata_q   <= cmd_wdata;
            rdata_q   <= 8'h00;
            if (req_op == CMD_ILL) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_ERR;
            end else begin
              // First byte is on the bus as CS falls, ahead of the first rising edge.
              wren_pend  <= (req_op != CMD_READ);
              OSPI_IO_o  <= (req_op == CMD_READ) ? OP_READ : OP_WREN;
              OSPI_IO_oe <= 1'b1;
              OSPI_CS0_b <= cmd_cs;
              OSPI_CS1_b <= ~cmd_cs;
              clk_en     <= 1'b1;
              state      <= ST_CS_SETUP;
            end
          end
        end
        ST_ERR: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_CS_SETUP: if (rise_evt) state <= ST_CMD;
        ST_CMD: begin
          if (fall_evt) begin
            if (wren_pend) begin
              OSPI_IO_oe <= 1'b0;
              OSPI_IO_o  <= 8'h00;
              state      <= ST_CS_HOLD;
            end else begin
              OSPI_IO_o <= addr_sh[ADDR_W-1 -: 8];
              addr_sh   <= addr_sh << 8;
              bcnt      <= '0;
              state     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (fall_evt) begin
            if (bcnt == BW'(ADDR_BYTES - 1)) begin
              bcnt <= '0;
              case (op_q)
                CMD_READ: begin
                  OSPI_IO_oe <= 1'b0;
                  OSPI_IO_o  <= 8'h00;
                  dcnt       <= '0;
                  state      <= (DUMMY_CYC > 0) ? ST_DUMMY : ST_DATA;
                end
                CMD_WRITE: begin
                  OSPI_IO_o <= wdata_q;
                  state     <= ST_DATA;
                end
                default: begin
                  OSPI_IO_oe <= 1'b0;
                  OSPI_IO_o  <= 8'h00;
                  state      <= ST_CS_HOLD;
                end
              endcase
            end else begin
              bcnt      <= bcnt + 1'b1;
              OSPI_IO_o <= addr_sh[ADDR_W-1 -: 8];
              addr_sh   <= addr_sh << 8;
            end
          end
        end
        ST_DUMMY: begin
          if (fall_evt) begin
            if (dcnt == DW'(DUMMY_CYC - 1)) begin
              dcnt  <= '0;
              state <= ST_DATA;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (rise_evt && op_q == CMD_READ) rdata_q <= OSPI_IO_i;
          if (fall_evt) begin
            OSPI_IO_oe <= 1'b0;
            OSPI_IO_o  <= 8'h00;
            state      <= ST_CS_HOLD;
          end
        end
        ST_CS_HOLD: begin
          if (rise_evt) begin
            OSPI_CS0_b <= 1'b1;
            OSPI_CS1_b <= 1'b1;
            gcnt       <= '0;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Half-period ticks: 2*CS_HIGH_MIN of them make CS_HIGH_MIN full periods.
          if (rise_evt) begin
            if (gcnt == GW'(2 * CS_HIGH_MIN - 1)) begin
              gcnt <= '0;
              if (wren_pend) begin
                wren_pend  <= 1'b0;
                OSPI_IO_o  <= opcode_of(op_q);
                OSPI_IO_oe <= 1'b1;
                OSPI_CS0_b <= cs_q;
                OSPI_CS1_b <= ~cs_q;
                state      <= ST_CS_SETUP;
              end else begin
                clk_en    <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_q;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= ST_IDLE;
              end
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Self-checking bench: pin monitor + flash responder, frame streams compared
// against sequences built from the protocol rules.
module tb_ospi_host_ctrl;

  localparam int CLK_DIV = 2, ADDR_W = 8, DUMMY_CYC = 4, CS_HIGH_MIN = 2, RST_CYC = 8;
  localparam int AB       = ADDR_W / 8;
  localparam int DATA_IDX = 1 + AB + DUMMY_CYC;
  localparam int ZB = 256, EOF = -1, SOF = 512;

  logic              clk = 1'b0, reset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_cs = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [7:0]        cmd_wdata = 8'h00;
  logic              rsp_valid, rsp_err, busy;
  logic [7:0]        rsp_rdata;
  logic              OSPI_CLK, OSPI_CS0_b, OSPI_CS1_b, OSPI_RST_b, OSPI_IO_oe;
  logic [7:0]        OSPI_IO_o, OSPI_IO_i = 8'h00;

  always #5 clk = ~clk;

  ospi_host_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC),
                   .CS_HIGH_MIN(CS_HIGH_MIN), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cs(cmd_cs), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .OSPI_CLK(OSPI_CLK), .OSPI_CS0_b(OSPI_CS0_b), .OSPI_CS1_b(OSPI_CS1_b),
    .OSPI_RST_b(OSPI_RST_b), .OSPI_IO_o(OSPI_IO_o), .OSPI_IO_oe(OSPI_IO_oe),
    .OSPI_IO_i(OSPI_IO_i)
  );

  int n_vec = 0, n_bad = 0;
  int obs[$], exp_q[$];
  int rise_n = 0, since_cs = 0, gap_n = 1 << 20, viol = 0, rsp_n = 0;
  logic p_sclk = 1'b0, p_cs0 = 1'b1, p_cs1 = 1'b1;
  bit cs_any, cs_any_p;
  logic [7:0] fbyte = 8'h00;

  // Pin monitor and flash responder, sampled mid-cycle.
  always @(negedge clk) begin
    cs_any   = !OSPI_CS0_b || !OSPI_CS1_b;
    cs_any_p = !p_cs0 || !p_cs1;
    if (!OSPI_CS0_b && !OSPI_CS1_b) begin viol++; $display("monitor: both CS low at %0t", $time); end
    if (cs_any && !cs_any_p) begin
      if (gap_n < 2 * CS_HIGH_MIN * CLK_DIV) begin viol++; $display("monitor: CS gap %0d clk at %0t", gap_n, $time); end
      obs.push_back(SOF + (OSPI_CS0_b ? 1 : 0));
      rise_n = 0; since_cs = 0;
      OSPI_IO_i = ~fbyte;
    end else if (cs_any) since_cs++;
    if (!cs_any && cs_any_p) begin obs.push_back(EOF); gap_n = 1; end
    else if (!cs_any && gap_n < (1 << 20)) gap_n++;
    if (!cs_any && (OSPI_IO_oe || OSPI_IO_o != 8'h00)) begin viol++; $display("monitor: IO driven with CS high at %0t", $time); end
    if (OSPI_CLK && !p_sclk) begin
      if (!cs_any) begin viol++; $display("monitor: OSPI_CLK rise with CS high at %0t", $time); end
      if (rise_n == 0 && since_cs != CLK_DIV) begin viol++; $display("monitor: CS setup %0d clk at %0t", since_cs, $time); end
      obs.push_back(OSPI_IO_oe ? int'(OSPI_IO_o) : ZB);
      rise_n++;
      OSPI_IO_i = (rise_n == DATA_IDX) ? fbyte : (~fbyte ^ 8'(rise_n));
    end
    if (rsp_valid) rsp_n++;
    p_sclk = OSPI_CLK; p_cs0 = OSPI_CS0_b; p_cs1 = OSPI_CS1_b;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pin-level stream: SOF+cs, bytes sampled at each rising edge (ZB when
  // the host is not driving), EOF when CS returns high.
  task automatic build_exp(input logic [1:0] op, input logic cs, input logic [ADDR_W-1:0] a,
                           input logic [7:0] wd);
    exp_q.delete();
    if (op == 2'b11) return;
    if (op != 2'b00) begin exp_q.push_back(SOF + int'(cs)); exp_q.push_back(8'h06); exp_q.push_back(EOF); end
    exp_q.push_back(SOF + int'(cs));
    exp_q.push_back(op == 2'b00 ? 8'h03 : (op == 2'b01 ? 8'h02 : 8'h20));
    for (int i = AB - 1; i >= 0; i--) exp_q.push_back(int'(a[i*8 +: 8]));
    if (op == 2'b00) repeat (DUMMY_CYC + 1) exp_q.push_back(ZB);
    if (op == 2'b01) exp_q.push_back(int'(wd));
    exp_q.push_back(EOF);
  endtask

  task automatic cmp_stream(input string name);
    int bi, ga, ex;
    bi = -1;
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      if (bi < 0 && obs[i] != exp_q[i]) bi = i;
    if (bi < 0 && obs.size() != exp_q.size()) bi = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    n_vec++;
    if (bi >= 0) begin
      n_bad++;
      ga = (bi < obs.size()) ? obs[bi] : -2;
      ex = (bi < exp_q.size()) ? exp_q[bi] : -2;
      $display("FAIL %s frames: item %0d got %0h expected %0h (%0d items, expected %0d)",
               name, bi, ga, ex, obs.size(), exp_q.size());
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic cs, input logic [ADDR_W-1:0] a,
                       input logic [7:0] wd);
    int k;
    k = 0;
    while (!cmd_ready && k < 500) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_ready before request", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cs = cs; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_cs = 1'($urandom);
    cmd_addr = ADDR_W'($urandom); cmd_wdata = 8'($urandom);
  endtask

  task automatic run_req(input string name, input logic [1:0] op, input logic cs,
                         input logic [ADDR_W-1:0] a, input logic [7:0] wd, input logic [7:0] fb,
                         input logic [7:0] exp_rd, input logic exp_err);
    int lat, rsp0, viol0;
    logic seen, er;
    logic [7:0] rd;
    fbyte = fb;
    build_exp(op, cs, a, wd);
    obs.delete();
    rsp0 = rsp_n; viol0 = viol;
    issue(op, cs, a, wd);
    check({name, " busy after accept"}, int'(busy), 1);
    lat = 1;
    while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
    seen = rsp_valid; rd = rsp_rdata; er = rsp_err;
    repeat (4) @(negedge clk);
    check({name, " rsp_valid seen"}, int'(seen), 1);
    check({name, " rsp_rdata"}, int'(rd), int'(exp_rd));
    check({name, " rsp_err"}, int'(er), int'(exp_err));
    if (op == 2'b11) check({name, " illegal rsp latency"}, lat, 1);
    cmp_stream(name);
    check({name, " rsp pulses"}, rsp_n - rsp0, 1);
    check({name, " pin rule breaches"}, viol - viol0, 0);
    check({name, " idle after rsp"}, int'({busy, cmd_ready}), 1);
  endtask

  task automatic rst_pulse(input string name);
    int n;
    n = 0;
    reset = 1'b0;
    do begin @(posedge clk); n++; @(negedge clk); end while (!OSPI_RST_b && n < 100);
    check({name, " RST_b low clk"}, n, RST_CYC);
    check({name, " ready after RST"}, int'({busy, cmd_ready}), 1);
  endtask

  typedef struct {
    logic [1:0] op; logic cs; logic [ADDR_W-1:0] addr; logic [7:0] wdata;
    logic [7:0] fb; logic [7:0] exp_rd; logic exp_err;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2000000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k, rsp0;
    logic [1:0] op; logic cs; logic [7:0] fb, wd; logic [ADDR_W-1:0] a;

    tbl[0] = '{2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 8'h10, 8'h3C, 8'hEE, 8'h00, 1'b0};
    tbl[2] = '{2'b10, 1'b0, 8'h80, 8'h00, 8'h11, 8'h00, 1'b0};
    tbl[3] = '{2'b11, 1'b1, 8'h55, 8'h66, 8'h22, 8'h00, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{2'b01, 1'b0, 8'hFF, 8'hFF, 8'h5A, 8'h00, 1'b0};
    tbl[6] = '{2'b00, 1'b0, 8'h01, 8'h00, 8'hFF, 8'hFF, 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", int'(cmd_ready), 0);
    check("reset rsp_valid", int'(rsp_valid), 0);
    check("reset rsp_rdata", int'(rsp_rdata), 0);
    check("reset rsp_err", int'(rsp_err), 0);
    check("reset busy", int'(busy), 1);
    check("reset OSPI_CLK", int'(OSPI_CLK), 0);
    check("reset CS_b", int'({OSPI_CS0_b, OSPI_CS1_b}), 3);
    check("reset RST_b", int'(OSPI_RST_b), 0);
    check("reset IO_o", int'(OSPI_IO_o), 0);
    check("reset IO_oe", int'(OSPI_IO_oe), 0);
    rst_pulse("post-reset");

    for (int i = 0; i < 7; i++)
      run_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].cs, tbl[i].addr, tbl[i].wdata,
              tbl[i].fb, tbl[i].exp_rd, tbl[i].exp_err);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3)); cs = 1'($urandom);
      a = ADDR_W'($urandom); wd = 8'($urandom); fb = 8'($urandom);
      run_req($sformatf("rnd%0d", i), op, cs, a, wd, fb,
              (op == 2'b00) ? fb : 8'h00, (op == 2'b11));
    end

    // Reset during the address byte of a READ aborts the frame with no response.
    fbyte = 8'h77;
    rsp0 = rsp_n;
    issue(2'b00, 1'b0, 8'h42, 8'h00);
    k = 0;
    while (!(rise_n >= 1 && !OSPI_CLK) && k < 500) begin @(negedge clk); #1; k++; end
    check("abort reached ADDR", int'(k < 500), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort CS_b", int'({OSPI_CS0_b, OSPI_CS1_b}), 3);
    check("abort IO_oe", int'(OSPI_IO_oe), 0);
    check("abort OSPI_CLK", int'(OSPI_CLK), 0);
    check("abort RST_b", int'(OSPI_RST_b), 0);
    rst_pulse("abort");
    repeat (3) @(negedge clk);
    check("abort rsp pulses", rsp_n - rsp0, 0);

    run_req("after-abort", 2'b00, 1'b1, 8'h3C, 8'h00, 8'hC3, 8'hC3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
